// File: rtl/ps2_cursor_scheduler.sv
// PS/2 scan-code decoder feeding a small command FIFO. One queued cursor command
// is applied per video frame, so the overlay square only moves during vertical blank.
module ps2_cursor_scheduler #(
   parameter int STEP       = 32,
   parameter int MAX_POS    = 224,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iByteValid,
   input  logic [7:0] iByte,
   input  logic       iParityOk,
   input  logic       iFrameStart,
   output logic [7:0] oXPos,
   output logic [7:0] oYPos,
   output logic [2:0] oColor,
   output logic [4:0] oFifoCount,
   output logic       oOverflow,
   output logic       oParityErr
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BRK     = 2'd1;
   localparam logic [1:0] ST_EXT     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   localparam logic [2:0] CMD_UP    = 3'd0;
   localparam logic [2:0] CMD_DOWN  = 3'd1;
   localparam logic [2:0] CMD_LEFT  = 3'd2;
   localparam logic [2:0] CMD_RIGHT = 3'd3;
   localparam logic [2:0] CMD_COLOR = 3'd4;

   localparam logic [4:0] DEPTH_5 = 5'(FIFO_DEPTH);
   localparam logic [8:0] STEP_9  = 9'(STEP);
   localparam logic [8:0] MAX_9   = 9'(MAX_POS);

   logic [1:0]       state_reg, state_next;
   logic             push_req;
   logic [2:0]       push_cmd;
   logic             byte_ok, parity_bad;

   logic [2:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [4:0]       count_reg, count_next;
   logic             fifo_full, fifo_empty;
   logic             do_pop, do_push;
   logic [2:0]       head_cmd;

   logic [7:0]       x_reg, x_next;
   logic [7:0]       y_reg, y_next;
   logic [2:0]       color_reg, color_next;
   logic             overflow_reg, overflow_next;
   logic             parity_err_reg;

   assign byte_ok    = iByteValid && iParityOk;
   assign parity_bad = iByteValid && !iParityOk;

   always_comb begin
      state_next = state_reg;
      push_req   = 1'b0;
      push_cmd   = CMD_UP;
      if (parity_bad) begin
         state_next = ST_IDLE;
      end else if (byte_ok) begin
         case (state_reg)
            ST_IDLE: begin
               case (iByte)
                  8'hF0: state_next = ST_BRK;
                  8'hE0: state_next = ST_EXT;
                  8'h1D: begin push_req = 1'b1; push_cmd = CMD_UP;    end
                  8'h1B: begin push_req = 1'b1; push_cmd = CMD_DOWN;  end
                  8'h1C: begin push_req = 1'b1; push_cmd = CMD_LEFT;  end
                  8'h23: begin push_req = 1'b1; push_cmd = CMD_RIGHT; end
                  8'h29: begin push_req = 1'b1; push_cmd = CMD_COLOR; end
                  default: state_next = ST_IDLE;
               endcase
            end
            ST_EXT: begin
               state_next = ST_IDLE;
               case (iByte)
                  8'hF0: state_next = ST_EXT_BRK;
                  8'h75: begin push_req = 1'b1; push_cmd = CMD_UP;    end
                  8'h72: begin push_req = 1'b1; push_cmd = CMD_DOWN;  end
                  8'h6B: begin push_req = 1'b1; push_cmd = CMD_LEFT;  end
                  8'h74: begin push_req = 1'b1; push_cmd = CMD_RIGHT; end
                  default: state_next = ST_IDLE;
               endcase
            end
            // Break sequences swallow the released key's code.
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign fifo_full  = (count_reg == DEPTH_5);
   assign fifo_empty = (count_reg == 5'd0);
   assign do_pop     = iFrameStart && !fifo_empty;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
   assign do_push    = push_req && (!fifo_full || do_pop);
   assign overflow_next = push_req && fifo_full && !do_pop;
   assign head_cmd   = fifo_mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 5'd1;
         2'b01:   count_next = count_reg - 5'd1;
         default: count_next = count_reg;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         always_ff @(posedge Clock) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi)))
               fifo_mem[gi] <= push_cmd;
         end
      end
   endgenerate

   always_comb begin
      x_next     = x_reg;
      y_next     = y_reg;
      color_next = color_reg;
      if (do_pop) begin
         case (head_cmd)
            CMD_UP:    y_next = ({1'b0, y_reg} >= STEP_9) ? 8'({1'b0, y_reg} - STEP_9) : 8'd0;
            CMD_DOWN:  y_next = ({1'b0, y_reg} + STEP_9 <= MAX_9) ? 8'({1'b0, y_reg} + STEP_9) : MAX_9[7:0];
            CMD_LEFT:  x_next = ({1'b0, x_reg} >= STEP_9) ? 8'({1'b0, x_reg} - STEP_9) : 8'd0;
            CMD_RIGHT: x_next = ({1'b0, x_reg} + STEP_9 <= MAX_9) ? 8'({1'b0, x_reg} + STEP_9) : MAX_9[7:0];
            // Colour 0 is reserved for the black frame, so the cycle is 1..7.
            CMD_COLOR: color_next = (color_reg == 3'd7) ? 3'd1 : color_reg + 3'd1;
            default:   color_next = color_reg;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg      <= ST_IDLE;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= 5'd0;
         x_reg          <= 8'd0;
         y_reg          <= 8'd0;
         color_reg      <= 3'b001;
         overflow_reg   <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         color_reg      <= color_next;
         overflow_reg   <= overflow_next;
         parity_err_reg <= parity_bad;
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end

   assign oXPos      = x_reg;
   assign oYPos      = y_reg;
   assign oColor     = color_reg;
   assign oFifoCount = count_reg;
   assign oOverflow  = overflow_reg;
   assign oParityErr = parity_err_reg;

endmodule

// File: tb/tb_ps2_cursor_scheduler.sv
// Directed bench for ps2_cursor_scheduler: scan-code sequences, frame pulses and
// hand-computed cursor, FIFO and status values.
module tb_ps2_cursor_scheduler;

   logic       Clock;
   logic       Reset;
   logic       iByteValid;
   logic [7:0] iByte;
   logic       iParityOk;
   logic       iFrameStart;
   logic [7:0] oXPos;
   logic [7:0] oYPos;
   logic [2:0] oColor;
   logic [4:0] oFifoCount;
   logic       oOverflow;
   logic       oParityErr;

   int vec_count  = 0;
   int miscompares = 0;

   ps2_cursor_scheduler #(.STEP(32), .MAX_POS(224), .FIFO_DEPTH(4)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iByteValid  (iByteValid),
      .iByte       (iByte),
      .iParityOk   (iParityOk),
      .iFrameStart (iFrameStart),
      .oXPos       (oXPos),
      .oYPos       (oYPos),
      .oColor      (oColor),
      .oFifoCount  (oFifoCount),
      .oOverflow   (oOverflow),
      .oParityErr  (oParityErr)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic par);
      @(negedge Clock);
      iByteValid = 1'b1;
      iByte      = b;
      iParityOk  = par;
      @(negedge Clock);
      iByteValid = 1'b0;
      iParityOk  = 1'b1;
   endtask

   task automatic frame_pulse();
      @(negedge Clock);
      iFrameStart = 1'b1;
      @(negedge Clock);
      iFrameStart = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge Clock);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      Reset       = 1'b1;
      iByteValid  = 1'b0;
      iByte       = 8'h00;
      iParityOk   = 1'b1;
      iFrameStart = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;

      check_vec("reset x", oXPos, 0);
      check_vec("reset y", oYPos, 0);
      check_vec("reset color", oColor, 1);
      check_vec("reset count", oFifoCount, 0);
      check_vec("reset overflow", oOverflow, 0);
      check_vec("reset parity", oParityErr, 0);

      // UP from 0 saturates, then DOWN lands one cycle after the pulse
      send_byte(8'h1D, 1'b1);
      check_vec("up queued count", oFifoCount, 1);
      frame_pulse();
      check_vec("up applied count", oFifoCount, 0);
      check_vec("up saturates y", oYPos, 0);
      send_byte(8'h1B, 1'b1);
      @(negedge Clock);
      iFrameStart = 1'b1;
      check_vec("down before edge y", oYPos, 0);
      @(negedge Clock);
      iFrameStart = 1'b0;
      check_vec("down after edge y", oYPos, 32);

      // Press and release D: one RIGHT only
      send_byte(8'h23, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h23, 1'b1);
      check_vec("make+break count", oFifoCount, 1);
      frame_pulse();
      check_vec("right applied x", oXPos, 32);
      frame_pulse();
      check_vec("empty frame x", oXPos, 32);
      check_vec("empty frame count", oFifoCount, 0);

      // Extended sequences
      send_byte(8'hE0, 1'b1); send_byte(8'h74, 1'b1);
      send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h74, 1'b1);
      send_byte(8'hE0, 1'b1); send_byte(8'h6B, 1'b1);
      check_vec("ext count", oFifoCount, 2);
      frame_pulse();
      check_vec("ext right x", oXPos, 64);
      frame_pulse();
      check_vec("ext left x", oXPos, 32);

      // Overflow on the fifth push
      for (int i = 0; i < 4; i++) send_byte(8'h1B, 1'b1);
      check_vec("full count", oFifoCount, 4);
      check_vec("no overflow at 4", oOverflow, 0);
      send_byte(8'h1B, 1'b1);
      check_vec("overflow pulse", oOverflow, 1);
      check_vec("overflow count", oFifoCount, 4);
      @(negedge Clock);
      check_vec("overflow one cycle", oOverflow, 0);
      @(negedge Clock);
      iByteValid = 1'b1; iByte = 8'h1B; iParityOk = 1'b1; iFrameStart = 1'b1;
      @(negedge Clock);
      iByteValid = 1'b0; iFrameStart = 1'b0;
      check_vec("push+pop full count", oFifoCount, 4);
      check_vec("push+pop no overflow", oOverflow, 0);
      check_vec("push+pop y", oYPos, 64);
      for (int i = 0; i < 4; i++) begin
         frame_pulse();
         check_vec($sformatf("drain y %0d", i), oYPos, 96 + 32 * i);
      end
      check_vec("drained count", oFifoCount, 0);

      // Colour cycle 2..7,1,2
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h29, 1'b1);
         frame_pulse();
         check_vec($sformatf("color step %0d", i), oColor, (i < 6) ? i + 2 : i - 5);
      end

      // Parity error
      send_byte(8'h23, 1'b0);
      check_vec("parity pulse", oParityErr, 1);
      check_vec("parity count", oFifoCount, 0);
      @(negedge Clock);
      check_vec("parity one cycle", oParityErr, 0);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h55, 1'b0);
      send_byte(8'h1D, 1'b1);
      check_vec("parity forces idle count", oFifoCount, 1);
      frame_pulse();
      check_vec("parity forces idle y", oYPos, 160);

      // Saturation at MAX_POS
      apply_reset();
      check_vec("rereset x", oXPos, 0);
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h23, 1'b1);
         frame_pulse();
         check_vec($sformatf("sat x %0d", i), oXPos, (i < 6) ? 32 * (i + 1) : 224);
      end

      // Async reset mid-sequence
      send_byte(8'h1B, 1'b1);
      send_byte(8'hF0, 1'b1);
      check_vec("pre-reset count", oFifoCount, 1);
      @(negedge Clock);
      #2 Reset = 1'b1;
      #1;
      check_vec("async reset x", oXPos, 0);
      check_vec("async reset count", oFifoCount, 0);
      check_vec("async reset color", oColor, 1);
      @(negedge Clock);
      Reset = 1'b0;
      send_byte(8'h1B, 1'b1);
      check_vec("fresh make count", oFifoCount, 1);
      frame_pulse();
      check_vec("fresh make y", oYPos, 32);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
